// File: rtl/debug_step_ctrl_pkg.sv
// Shared definitions for the debug step controller.
//   - Default command byte values (UART ASCII letters).
//   - Controller and serializer state encodings.
//   - nbytes(): number of bytes needed to send a PC of a given width.
package debug_step_ctrl_pkg;

    localparam logic [7:0] CMD_RUN_DEF  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP_DEF = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLR_DEF  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_READ_DEF = 8'h70;  // 'p'
    localparam logic [7:0] CMD_STOP_DEF = 8'h78;  // 'x'

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StClr,
        StSend
    } ctrl_state_e;

    typedef enum logic {
        TxIdle = 1'b0,
        TxSend = 1'b1
    } tx_state_e;

    function automatic int unsigned nbytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Report serializer: captures a PC word on a load strobe and sends it LSB byte first over a
// valid/ready byte stream. The top byte is zero-padded when PC_WIDTH is not a multiple of 8.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-low reset
//   load     in   capture word and start sending (ignored while a report is in flight)
//   word     in   PC value to report
//   txValid  out  byte valid (held until txReady)
//   txData   out  current byte, 0 when idle
//   txReady  in   byte accepted on txValid && txReady
//   done     out  one-cycle pulse coinciding with the transfer of the last byte
module debug_tx_serializer
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] word,
    output logic                txValid,
    output logic [7:0]          txData,
    input  logic                txReady,
    output logic                done
);

    localparam int unsigned NBYTES = nbytes(PC_WIDTH);
    localparam int unsigned BUF_W  = NBYTES * 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    tx_state_e          state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               last_byte;

    assign last_byte = (idx_q == CNT_W'(NBYTES - 1));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        done    = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (load) begin
                    buf_d                 = '0;
                    buf_d[PC_WIDTH-1:0]   = word;
                    idx_d                 = '0;
                    state_d               = TxSend;
                end
            end
            TxSend: begin
                if (txReady) begin
                    // Shifting right leaves the buffer all-zero after the last byte,
                    // so txData returns to 0 when the report completes.
                    buf_d = buf_q >> 8;
                    if (last_byte) begin
                        idx_d   = '0;
                        state_d = TxIdle;
                        done    = 1'b1;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= TxIdle;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    assign txValid = (state_q == TxSend);
    assign txData  = buf_q[7:0];

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug-side master for the fetch-stage register. Decodes 1-byte commands from the debug
// UART RX path, drives debugEnable/debugReset into the fetch stage and reports the latched
// PC back on the TX path, LSB byte first.
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-low reset
//   rxValid      in   command byte available
//   rxData       in   command byte
//   rxReady      out  byte consumed on rxValid && rxReady (IDLE and RUN only)
//   txValid      out  report byte valid
//   txData       out  report byte
//   txReady      in   report byte accepted on txValid && txReady
//   pcIn         in   PC latched by the fetch stage
//   halt         in   pipeline reached a halt instruction
//   debugEnable  out  advance enable to the fetch stage
//   debugReset   out  clear to the fetch stage
//   busy         out  controller not idle
module debug_step_ctrl
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8,
    parameter logic [7:0]  CMD_RUN  = CMD_RUN_DEF,
    parameter logic [7:0]  CMD_STEP = CMD_STEP_DEF,
    parameter logic [7:0]  CMD_CLR  = CMD_CLR_DEF,
    parameter logic [7:0]  CMD_READ = CMD_READ_DEF,
    parameter logic [7:0]  CMD_STOP = CMD_STOP_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rxValid,
    input  logic [7:0]          rxData,
    output logic                rxReady,
    output logic                txValid,
    output logic [7:0]          txData,
    input  logic                txReady,
    input  logic [PC_WIDTH-1:0] pcIn,
    input  logic                halt,
    output logic                debugEnable,
    output logic                debugReset,
    output logic                busy
);

    ctrl_state_e state_q, state_d;
    // settle_q: enable has been dropped; the fetch stage updates during this cycle and the
    // PC is captured at its end. Shared by RUN (after halt/stop) and STEP.
    logic        settle_q, settle_d;
    logic        enable_q, enable_d;
    logic        clear_q, clear_d;
    logic        rx_fire;
    logic        load;
    logic        tx_done;

    assign rxReady = (state_q == StIdle) || (state_q == StRun);
    assign busy    = (state_q != StIdle);
    assign rx_fire = rxValid && rxReady;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        enable_d = 1'b0;
        clear_d  = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                settle_d = 1'b0;
                if (rx_fire) begin
                    if (rxData == CMD_RUN) begin
                        state_d  = StRun;
                        enable_d = 1'b1;
                    end else if (rxData == CMD_STEP) begin
                        state_d  = StStep;
                        enable_d = 1'b1;
                    end else if (rxData == CMD_CLR) begin
                        state_d = StClr;
                        clear_d = 1'b1;
                    end else if (rxData == CMD_READ) begin
                        state_d = StSend;
                        load    = 1'b1;
                    end
                    // STOP and unknown bytes are consumed and dropped.
                end
            end
            StRun: begin
                if (settle_q) begin
                    state_d  = StSend;
                    settle_d = 1'b0;
                    load     = 1'b1;
                end else if (halt || (rx_fire && rxData == CMD_STOP)) begin
                    settle_d = 1'b1;
                end else begin
                    enable_d = 1'b1;
                end
            end
            StStep: begin
                // Entered with enable already high for one clock; halt is not consulted.
                if (settle_q) begin
                    state_d  = StSend;
                    settle_d = 1'b0;
                    load     = 1'b1;
                end else begin
                    settle_d = 1'b1;
                end
            end
            StClr: begin
                state_d = StIdle;
            end
            StSend: begin
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                settle_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            settle_q <= 1'b0;
            enable_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
        end
    end

    assign debugEnable = enable_q;
    assign debugReset  = clear_q;

    // The serializer captures pcIn on load, so it also holds the reported PC.
    debug_tx_serializer #(
        .PC_WIDTH (PC_WIDTH)
    ) u_tx (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .word    (pcIn),
        .txValid (txValid),
        .txData  (txData),
        .txReady (txReady),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl with PC_WIDTH=12 (two-byte reports). A simple fetch-stage model
// increments its PC on each falling edge with debugEnable high and clears it on debugReset.
// Each command is checked at transaction level: number of enable/reset cycles and the bytes
// of the report, computed from the command semantics.
module tb_debug_step_ctrl;

    localparam int unsigned PW = 12;
    localparam logic [7:0] C_RUN  = 8'h63;
    localparam logic [7:0] C_STEP = 8'h73;
    localparam logic [7:0] C_CLR  = 8'h72;
    localparam logic [7:0] C_READ = 8'h70;
    localparam logic [7:0] C_STOP = 8'h78;

    logic          clock = 1'b0;
    logic          reset;
    logic          rxValid;
    logic [7:0]    rxData;
    logic          rxReady;
    logic          txValid;
    logic [7:0]    txData;
    logic          txReady;
    logic [PW-1:0] pcIn;
    logic          halt;
    logic          debugEnable;
    logic          debugReset;
    logic          busy;

    always #5 clock = ~clock;

    debug_step_ctrl #(
        .PC_WIDTH (PW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rxValid     (rxValid),
        .rxData      (rxData),
        .rxReady     (rxReady),
        .txValid     (txValid),
        .txData      (txData),
        .txReady     (txReady),
        .pcIn        (pcIn),
        .halt        (halt),
        .debugEnable (debugEnable),
        .debugReset  (debugReset),
        .busy        (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Fetch-stage model; main loads a PC by setting load_val and toggling load_tgl.
    logic [PW-1:0] fpc;
    logic [PW-1:0] load_val = '0;
    logic          load_tgl = 1'b0;
    logic          seen_tgl;
    assign pcIn = fpc;

    initial begin
        fpc      = PW'($urandom);
        seen_tgl = 1'b0;
        forever begin
            @(negedge clock);
            if (load_tgl != seen_tgl) begin
                fpc      = load_val;
                seen_tgl = load_tgl;
            end else if (debugReset) begin
                fpc = '0;
            end else if (debugEnable) begin
                fpc = fpc + PW'(1);
            end
        end
    end

    // txReady: random 75% accept unless forced low.
    logic rdy_low = 1'b0;
    initial begin
        txReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            txReady = rdy_low ? 1'b0 : 1'(($urandom & 3) != 0);
        end
    end

    // Monitor: cycle counters, transfer log, stall stability and exclusivity.
    int         en_cnt  = 0;
    int         rst_cnt = 0;
    int         txv_cnt = 0;
    logic [7:0] tx_log[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                check_eq("excl", 32'(debugEnable & debugReset), 32'd0);
                if (prev_stall) begin
                    check_eq("stall_valid", 32'(txValid), 32'd1);
                    check_eq("stall_data", 32'(txData), 32'(prev_data));
                end
                if (debugEnable) en_cnt++;
                if (debugReset) rst_cnt++;
                if (txValid) txv_cnt++;
                if (txValid && txReady) tx_log.push_back(txData);
                prev_stall = txValid && !txReady;
                prev_data  = txData;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_pc(input logic [PW-1:0] v);
        load_val = v;
        load_tgl = ~load_tgl;
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    // Returns 1ns after the edge that consumed the byte.
    task automatic send_cmd(input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clock);
        #1;
        rxValid = 1'b1;
        rxData  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (rxReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("rx_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic expect_report(input string tag, input logic [PW-1:0] p, input int li);
        bit         idle = 1'b0;
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = p[7:0];
        b1 = {4'h0, p[11:8]};
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check_eq({tag, "_done"}, 32'(idle), 32'd1);
        repeat (3) @(negedge clock);
        check_eq({tag, "_nbytes"}, 32'(tx_log.size() - li), 32'd2);
        if (tx_log.size() - li == 2) begin
            check_eq({tag, "_byte0"}, 32'(tx_log[li]), 32'(b0));
            check_eq({tag, "_byte1"}, 32'(tx_log[li+1]), 32'(b1));
        end
        check_eq({tag, "_txv_idle"}, 32'(txValid), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_read();
        logic [PW-1:0] p0 = fpc;
        int li = tx_log.size();
        int e0 = en_cnt;
        send_cmd(C_READ);
        expect_report("read", p0, li);
        check_eq("read_en", 32'(en_cnt - e0), 32'd0);
    endtask

    task automatic do_step();
        logic [PW-1:0] p0 = fpc;
        int li = tx_log.size();
        int e0 = en_cnt;
        send_cmd(C_STEP);
        expect_report("step", PW'(p0 + 1), li);
        check_eq("step_en", 32'(en_cnt - e0), 32'd1);
    endtask

    // mode 0: halt, 1: STOP byte, 2: both in the same cycle. With extra, an 's' is sent
    // during RUN and must be dropped. The stop condition is sampled k+1 edges after RUN entry.
    task automatic do_run(input int k, input int mode, input bit extra);
        logic [PW-1:0] p0 = fpc;
        int li = tx_log.size();
        int e0 = en_cnt;
        send_cmd(C_RUN);
        check_eq("run_busy", 32'(busy), 32'd1);
        for (int j = 0; j < k; j++) begin
            rxValid = extra && (j == 0);
            rxData  = C_STEP;
            @(posedge clock);
            #1;
        end
        rxValid = 1'b0;
        if (mode != 1) halt = 1'b1;
        if (mode != 0) begin
            rxValid = 1'b1;
            rxData  = C_STOP;
        end
        @(posedge clock);
        #1;
        rxValid = 1'b0;
        expect_report("run", PW'(p0 + PW'(k) + PW'(1)), li);
        halt = 1'b0;
        check_eq("run_en", 32'(en_cnt - e0), 32'(k + 1));
    endtask

    task automatic do_quiet(input string tag, input logic [7:0] b, input int exp_rst);
        int li = tx_log.size();
        int e0 = en_cnt;
        int r0 = rst_cnt;
        int t0 = txv_cnt;
        send_cmd(b);
        repeat (4) @(negedge clock);
        check_eq({tag, "_rst"}, 32'(rst_cnt - r0), 32'(exp_rst));
        check_eq({tag, "_en"}, 32'(en_cnt - e0), 32'd0);
        check_eq({tag, "_txv"}, 32'(txv_cnt - t0), 32'd0);
        check_eq({tag, "_log"}, 32'(tx_log.size() - li), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_rxrdy"}, 32'(rxReady), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq({tag, "_en"}, 32'(debugEnable), 32'd0);
        check_eq({tag, "_clr"}, 32'(debugReset), 32'd0);
        check_eq({tag, "_txv"}, 32'(txValid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_rxrdy"}, 32'(rxReady), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int li;
        reset   = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        halt    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_en", 32'(debugEnable), 32'd0);
        check_eq("rst_clr", 32'(debugReset), 32'd0);
        check_eq("rst_txv", 32'(txValid), 32'd0);
        check_eq("rst_txd", 32'(txData), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rxrdy", 32'(rxReady), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Clear, run to PC 4, then a single step to 5.
        do_quiet("clr", C_CLR, 1);
        do_run(3, 0, 1'b0);
        do_step();
        // Run with halt after 10 cycles, then read back the same PC.
        do_run(10, 0, 1'b0);
        do_read();

        // 12-bit PC read with a forced TX stall.
        set_pc(12'hABC);
        rdy_low = 1'b1;
        li = tx_log.size();
        send_cmd(C_READ);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_eq("stall_hold_v", 32'(txValid), 32'd1);
            check_eq("stall_hold_d", 32'(txData), 32'hBC);
        end
        rdy_low = 1'b0;
        expect_report("read_abc", 12'hABC, li);

        do_quiet("ign41", 8'h41, 0);
        do_quiet("ignstop", C_STOP, 0);
        do_run(6, 1, 1'b1);
        do_run(0, 0, 1'b0);
        do_run(4, 2, 1'b0);
        do_read();

        for (int it = 0; it < 40; it++) begin
            int         op = int'($urandom_range(0, 6));
            int         k  = int'($urandom_range(0, 12));
            logic [7:0] b;
            case (op)
                0: do_read();
                1: do_step();
                2: do_run(k, 0, 1'b0);
                3: do_run(k, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
                4: do_quiet("clr_r", C_CLR, 1);
                5: begin
                    b = 8'($urandom);
                    if (b == C_RUN || b == C_STEP || b == C_CLR || b == C_READ) b = 8'h41;
                    do_quiet("ign_r", b, 0);
                end
                default: set_pc(PW'($urandom));
            endcase
        end

        // Reset in the middle of RUN: no report may follow.
        li = tx_log.size();
        send_cmd(C_RUN);
        repeat (4) @(posedge clock);
        reset_pulse("rst_run");
        repeat (4) @(negedge clock);
        check_eq("rst_run_log", 32'(tx_log.size() - li), 32'd0);
        check_eq("rst_run_idle", 32'(busy), 32'd0);

        // Reset in the middle of SEND: partial report is discarded.
        rdy_low = 1'b1;
        li = tx_log.size();
        send_cmd(C_READ);
        @(negedge clock);
        check_eq("rst_send_pre_v", 32'(txValid), 32'd1);
        @(posedge clock);
        reset_pulse("rst_send");
        rdy_low = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("rst_send_log", 32'(tx_log.size() - li), 32'd0);
        check_eq("rst_send_txv", 32'(txValid), 32'd0);
        @(posedge clock);
        #1;
        do_read();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
